// File: rtl/ofdm_cp_insert.sv
// rtl/ofdm_cp_insert.sv - cyclic-prefix insertion for OFDM symbols
// Ping-pong symbol buffer; the read FSM replays the symbol tail as prefix, then the body.
module ofdm_cp_insert #(
  parameter int DATA_W = 16,
  parameter int NFFT   = 64,
  parameter int CP_MAX = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(CP_MAX+1)-1:0]  cp_len,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_data_i,
  input  logic [DATA_W-1:0]            s_data_q,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_W-1:0]            m_data_i,
  output logic [DATA_W-1:0]            m_data_q,
  output logic                         m_first,
  output logic                         m_last,
  output logic                         err_framing
);

  localparam int AW  = $clog2(NFFT);
  localparam int CLW = $clog2(CP_MAX+1);

  typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

  logic [DATA_W-1:0] mem_i [2*NFFT];
  logic [DATA_W-1:0] mem_q [2*NFFT];

  // Write side
  logic          run_q;
  logic [AW-1:0] wr_cnt_q;
  logic          wr_bank_q;
  logic [1:0]    full_q, full_d;
  logic          err_q;
  logic          rel_bank_q, rel_bank_d;

  // Read side and registered outputs
  state_t            state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [AW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CLW-1:0]    len_q, len_d;
  logic              first_pend_q, first_pend_d;
  logic              mv_q, mv_d;
  logic [DATA_W-1:0] mdi_q, mdi_d, mdq_q, mdq_d;
  logic              mf_q, mf_d, ml_q, ml_d;

  logic              rel, wr_fire, wr_end, ld;
  logic [CLW-1:0]    len_in;
  logic [AW-1:0]     start_cnt;
  state_t            start_state;
  logic [DATA_W-1:0] rd_i, rd_q;

  // A bank released this cycle may be refilled in the same cycle
  assign rel     = mv_q & m_ready & ml_q;
  assign s_ready = run_q & (~full_q[wr_bank_q] | (rel & (rel_bank_q == wr_bank_q)));
  assign wr_fire = s_valid & s_ready;
  assign wr_end  = wr_fire & (wr_cnt_q == AW'(NFFT-1));

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_i[{wr_bank_q, wr_cnt_q}] <= s_data_i;
      mem_q[{wr_bank_q, wr_cnt_q}] <= s_data_q;
    end
  end

  assign rd_i = mem_i[{rd_bank_q, rd_cnt_q}];
  assign rd_q = mem_q[{rd_bank_q, rd_cnt_q}];

  always_comb begin
    full_d = full_q;
    if (rel)    full_d[rel_bank_q] = 1'b0;
    if (wr_end) full_d[wr_bank_q]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      full_q <= full_d;
      if (wr_fire) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (s_last != (wr_cnt_q == AW'(NFFT-1))) err_q <= 1'b1;
        if (wr_end) wr_bank_q <= ~wr_bank_q;
      end
    end
  end

  assign len_in      = (32'(cp_len) > CP_MAX) ? CLW'(CP_MAX) : cp_len;
  assign start_state = (len_in == '0) ? BODY : CP;
  assign start_cnt   = (len_in == '0) ? '0 : AW'(NFFT - 32'(len_in));
  assign ld          = ~mv_q | m_ready;

  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rd_cnt_d     = rd_cnt_q;
    len_d        = len_q;
    first_pend_d = first_pend_q;
    rel_bank_d   = rel_bank_q;
    mv_d         = mv_q;
    mdi_d        = mdi_q;
    mdq_d        = mdq_q;
    mf_d         = mf_q;
    ml_d         = ml_q;
    if (ld) begin
      mv_d = 1'b0;
      mf_d = 1'b0;
      ml_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          len_d        = len_in;
          first_pend_d = 1'b1;
          state_d      = start_state;
          rd_cnt_d     = start_cnt;
        end
      end
      CP, BODY: begin
        if (ld) begin
          mv_d         = 1'b1;
          mdi_d        = rd_i;
          mdq_d        = rd_q;
          mf_d         = first_pend_q;
          first_pend_d = 1'b0;
          rd_cnt_d     = rd_cnt_q + 1'b1;
          if (rd_cnt_q == AW'(NFFT-1)) begin
            if (state_q == CP) begin
              state_d = BODY;
            end else begin
              // Chain straight into the next bank so symbols leave without bubbles
              ml_d       = 1'b1;
              rel_bank_d = rd_bank_q;
              rd_bank_d  = ~rd_bank_q;
              if (full_q[~rd_bank_q]) begin
                len_d        = len_in;
                first_pend_d = 1'b1;
                state_d      = start_state;
                rd_cnt_d     = start_cnt;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_bank_q    <= 1'b0;
      rd_cnt_q     <= '0;
      len_q        <= '0;
      first_pend_q <= 1'b0;
      rel_bank_q   <= 1'b0;
      mv_q         <= 1'b0;
      mdi_q        <= '0;
      mdq_q        <= '0;
      mf_q         <= 1'b0;
      ml_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_bank_q    <= rd_bank_d;
      rd_cnt_q     <= rd_cnt_d;
      len_q        <= len_d;
      first_pend_q <= first_pend_d;
      rel_bank_q   <= rel_bank_d;
      mv_q         <= mv_d;
      mdi_q        <= mdi_d;
      mdq_q        <= mdq_d;
      mf_q         <= mf_d;
      ml_q         <= ml_d;
    end
  end

  assign m_valid     = mv_q;
  assign m_data_i    = mdi_q;
  assign m_data_q    = mdq_q;
  assign m_first     = mf_q;
  assign m_last      = ml_q;
  assign err_framing = err_q;

endmodule
